mem_bus_arbiter: RTL and testbench

- Shares the single external memory read/write port between the I-cache refill engine and the D-cache refill/writeback engine.
- Grants one burst transaction at a time and tracks it to completion with a beat counter.
- Routes read beats back to the owning cache and generates each cache's last-beat indication.
- Feeds the pipeline control unit indirectly: a cache stays stalled until its transaction completes here.

---
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one external burst memory port between the I-cache and D-cache refill engines.
// Round-robin on contention, one burst in flight, beat counter tracks completion.
//
// state | meaning
// IDLE  | no transaction; arbitrate between ic_req and dc_req
// REQ   | m_req held with latched fields until m_ack
// RD    | forwarding read beats to the owner
// WR    | streaming D-cache write beats to memory
// WRESP | waiting for the write response
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [LEN_W-1:0]  ic_len,
  output logic              ic_gnt,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_rlast,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LEN_W-1:0]  dc_len,
  output logic              dc_gnt,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_rlast,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wready,
  output logic              dc_bdone,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LEN_W-1:0]  m_len,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic              m_bvalid
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, WRESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;      // 1 = D-cache owns the port
  logic                last_dc_q, last_dc_d;  // 1 = last grant went to D-cache
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                m_req_q, m_req_d;
  logic                m_wr_q, m_wr_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [LEN_W-1:0]    m_len_q, m_len_d;

  logic pick_dc;
  logic last_beat;
  logic in_req, in_rd, in_wr;

  // Under contention the requester that did not win last time takes the port.
  assign pick_dc   = dc_req && (!ic_req || !last_dc_q);
  assign last_beat = (cnt_q == m_len_q);
  assign in_req    = (state_q == REQ);
  assign in_rd     = (state_q == RD);
  assign in_wr     = (state_q == WR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_dc_q <= 1'b0;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_len_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_dc_q <= last_dc_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_len_q   <= m_len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_dc_d = last_dc_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_len_d   = m_len_q;
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          owner_d   = pick_dc;
          last_dc_d = pick_dc;
          m_req_d   = 1'b1;
          m_wr_d    = pick_dc && dc_wr;
          m_addr_d  = pick_dc ? dc_addr : ic_addr;
          m_len_d   = pick_dc ? dc_len : ic_len;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = m_wr_q ? WR : RD;
        end
      end
      RD: begin
        if (m_rvalid) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR: begin
        if (m_wready) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = WRESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRESP: begin
        if (m_bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ic_gnt    = in_req && m_ack && !owner_q;
  assign dc_gnt    = in_req && m_ack && owner_q;

  // Read data is gated so every output sits at zero outside the owner's read phase.
  assign ic_rvalid = in_rd && !owner_q && m_rvalid;
  assign dc_rvalid = in_rd && owner_q && m_rvalid;
  assign ic_rdata  = (in_rd && !owner_q) ? m_rdata : '0;
  assign dc_rdata  = (in_rd && owner_q) ? m_rdata : '0;
  assign ic_rlast  = ic_rvalid && last_beat;
  assign dc_rlast  = dc_rvalid && last_beat;

  assign m_wvalid  = in_wr;
  assign m_wdata   = in_wr ? dc_wdata : '0;
  assign dc_wready = in_wr && m_wready;
  assign dc_bdone  = (state_q == WRESP) && m_bvalid;

  assign m_req     = m_req_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_len     = m_len_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: bench plays both caches and the memory,
// expected read beats go through a scoreboard queue checked by a negedge monitor.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ic_req, dc_req, dc_wr;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] ic_len, dc_len;
  logic          ic_gnt, ic_rvalid, ic_rlast, dc_gnt, dc_rvalid, dc_rlast;
  logic [DW-1:0] ic_rdata, dc_rdata, dc_wdata, m_rdata, m_wdata;
  logic          dc_wready, dc_bdone, m_req, m_wr, m_ack, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic          m_wvalid, m_wready, m_bvalid;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_len(ic_len), .ic_gnt(ic_gnt),
    .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_len(dc_len), .dc_gnt(dc_gnt),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
    .dc_wdata(dc_wdata), .dc_wready(dc_wready), .dc_bdone(dc_bdone),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len), .m_ack(m_ack),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_wdata(m_wdata), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bvalid(m_bvalid)
  );

  typedef struct {
    bit            dc;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  bit    gnt_log[$];
  beat_t mb;
  int    checks = 0;
  int    errors = 0;
  int    mreq_cyc = 0;
  int    wready_cnt = 0;
  int    bdone_cnt = 0;
  bit    ic_wait = 0;
  bit    dc_wait = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {|ic_rdata, |dc_rdata, |m_addr, |m_wdata, m_len, ic_gnt, ic_rvalid, ic_rlast,
              dc_gnt, dc_rvalid, dc_rlast, dc_wready, dc_bdone, m_req, m_wr, m_wvalid}, 64'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      ic_wait = 0;
      dc_wait = 0;
    end else begin
      if (m_req) mreq_cyc++;
      if (ic_gnt) gnt_log.push_back(1'b0);
      if (dc_gnt) gnt_log.push_back(1'b1);
      if (dc_wready) begin
        wready_cnt++;
        chk("m_wdata_beat", m_wdata, dc_wdata);
      end
      if (dc_bdone) bdone_cnt++;
      if (ic_rvalid || dc_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {ic_rvalid, dc_rvalid}, 2'b00);
        end else begin
          mb = exp_q.pop_front();
          chk("rvalid_owner", {ic_rvalid, dc_rvalid}, mb.dc ? 2'b01 : 2'b10);
          chk("rdata", mb.dc ? dc_rdata : ic_rdata, mb.data);
          chk("rlast", mb.dc ? dc_rlast : ic_rlast, mb.last);
        end
      end
      if (ic_wait) chk("ic_req_held_until_gnt", ic_req, 1'b1);
      if (dc_wait) chk("dc_req_held_until_gnt", dc_req, 1'b1);
      ic_wait = ic_req && !ic_gnt;
      dc_wait = dc_req && !dc_gnt;
    end
  end

  task automatic wait_req_and_ack(input bit dc, input logic [AW-1:0] addr, input int len,
                                  input bit wr, input int ack_dly);
    int n = 0;
    while (!m_req && n < 20) begin
      cyc();
      n++;
    end
    chk("m_req_seen", m_req, 1'b1);
    chk("m_addr", m_addr, addr);
    chk("m_len", m_len, len);
    chk("m_wr", m_wr, wr);
    mreq_cyc = 0;
    repeat (ack_dly) cyc();
    m_ack = 1'b1;
    cyc();
    m_ack = 1'b0;
    chk("m_req_cycles", mreq_cyc, ack_dly + 1);
    chk("m_req_drop", m_req, 1'b0);
    chk("gnt_count", gnt_log.size(), 1);
    if (gnt_log.size() > 0) chk("gnt_owner", gnt_log.pop_front(), dc);
    gnt_log.delete();
  endtask

  task automatic serve_read(input bit dc, input logic [AW-1:0] addr, input int len,
                            input int ack_dly, input int gap, input bit keep, input bit spur_b);
    logic [DW-1:0] d;
    int b0;
    wait_req_and_ack(dc, addr, len, 1'b0, ack_dly);
    if (!keep) begin
      if (dc) dc_req = 1'b0;
      else ic_req = 1'b0;
    end
    b0 = bdone_cnt;
    m_bvalid = spur_b;
    for (int i = 0; i <= len; i++) begin
      d = $urandom;
      m_rdata = d;
      m_rvalid = 1'b1;
      exp_q.push_back('{dc, d, (i == len)});
      cyc();
      m_rvalid = 1'b0;
      m_rdata = '0;
      if (i < len) repeat (gap) cyc();
    end
    m_bvalid = 1'b0;
    chk("read_all_beats_seen", exp_q.size(), 0);
    chk("no_bdone_in_read", bdone_cnt, b0);
  endtask

  task automatic serve_write(input logic [AW-1:0] addr, input int len);
    int beat = 0;
    int n = 0;
    bit tog = 1'b1;
    int b0;
    wait_req_and_ack(1'b1, addr, len, 1'b1, 0);
    dc_req = 1'b0;
    wready_cnt = 0;
    while (beat <= len && n < 100) begin
      dc_wdata = $urandom;
      m_wready = tog;
      #1;
      chk("m_wvalid_during_wr", m_wvalid, 1'b1);
      chk("m_wdata_track", m_wdata, dc_wdata);
      cyc();
      if (tog) beat++;
      tog = !tog;
      n++;
    end
    m_wready = 1'b0;
    chk("wready_count", wready_cnt, len + 1);
    chk("m_wvalid_off", m_wvalid, 1'b0);
    b0 = bdone_cnt;
    repeat (2) cyc();
    chk("bdone_not_early", bdone_cnt, b0);
    m_bvalid = 1'b1;
    cyc();
    m_bvalid = 1'b0;
    chk("bdone_pulse", bdone_cnt, b0 + 1);
    cyc();
    chk("bdone_once", bdone_cnt, b0 + 1);
  endtask

  initial begin
    int n;
    int b0;
    resetn = 1'b0;
    ic_req = 0; ic_addr = '0; ic_len = '0;
    dc_req = 0; dc_wr = 0; dc_addr = '0; dc_len = '0; dc_wdata = '0;
    m_ack = 0; m_rdata = '0; m_rvalid = 0; m_wready = 0; m_bvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");

    // Contention straight out of reset: DC first, then strict alternation while both hold.
    ic_req = 1; ic_addr = 32'h0000_1000; ic_len = 4'd0;
    dc_req = 1; dc_wr = 0; dc_addr = 32'h0000_2000; dc_len = 4'd1;
    resetn = 1'b1;
    serve_read(1'b1, 32'h0000_2000, 1, 0, 0, 1'b0, 1'b0);
    serve_read(1'b0, 32'h0000_1000, 0, 0, 0, 1'b1, 1'b0);
    dc_req = 1; dc_addr = 32'h0000_3000; dc_len = 4'd0;
    serve_read(1'b1, 32'h0000_3000, 0, 0, 0, 1'b1, 1'b0);
    serve_read(1'b0, 32'h0000_1000, 0, 0, 0, 1'b1, 1'b0);
    serve_read(1'b1, 32'h0000_3000, 0, 0, 0, 1'b0, 1'b0);
    serve_read(1'b0, 32'h0000_1000, 0, 0, 0, 1'b0, 1'b0);

    // I-cache alone, delayed ack, gapped beats.
    cyc();
    ic_req = 1; ic_addr = 32'h1FC0_0000; ic_len = 4'd3;
    serve_read(1'b0, 32'h1FC0_0000, 3, 1, 1, 1'b0, 1'b0);

    // D-cache write burst of 8 beats.
    dc_req = 1; dc_wr = 1; dc_addr = 32'h8000_0040; dc_len = 4'd7;
    serve_write(32'h8000_0040, 7);
    dc_wr = 0;

    // Maximum length read with a spurious write response, then single beat read.
    ic_req = 1; ic_addr = 32'h0000_5000; ic_len = 4'd15;
    serve_read(1'b0, 32'h0000_5000, 15, 0, 0, 1'b0, 1'b1);
    dc_req = 1; dc_addr = 32'h0000_4000; dc_len = 4'd0;
    serve_read(1'b1, 32'h0000_4000, 0, 2, 0, 1'b0, 1'b0);

    // Memory-side strobes while idle must be ignored.
    cyc();
    b0 = bdone_cnt;
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_bvalid = 1; m_wready = 1; m_ack = 1;
    repeat (3) cyc();
    m_rvalid = 0; m_rdata = '0; m_bvalid = 0; m_wready = 0; m_ack = 0;
    chk("idle_no_m_req", m_req, 1'b0);
    chk("idle_no_bdone", bdone_cnt, b0);
    chk("idle_no_gnt", gnt_log.size(), 0);

    // Reset during beat 2 of a 4-beat read.
    ic_req = 1; ic_addr = 32'h0000_6000; ic_len = 4'd3;
    n = 0;
    while (!m_req && n < 20) begin
      cyc();
      n++;
    end
    chk("rst_m_req_seen", m_req, 1'b1);
    m_ack = 1;
    cyc();
    m_ack = 0;
    ic_req = 0;
    chk("rst_gnt_owner", (gnt_log.size() == 1) ? gnt_log.pop_front() : 1'bx, 1'b0);
    gnt_log.delete();
    b0 = bdone_cnt;
    m_rvalid = 1; m_rdata = $urandom;
    exp_q.push_back('{1'b0, m_rdata, 1'b0});
    cyc();
    resetn = 1'b0;
    m_rdata = $urandom;
    #1;
    chk_zero("async_reset_outputs");
    cyc();
    m_rvalid = 0; m_rdata = '0;
    chk_zero("reset_held_outputs");
    resetn = 1'b1;
    cyc();
    chk("post_reset_idle", m_req, 1'b0);
    chk("post_reset_no_beats_left", exp_q.size(), 0);
    chk("post_reset_no_bdone", bdone_cnt, b0);

    ic_req = 1; ic_addr = 32'h0000_7000; ic_len = 4'd1;
    serve_read(1'b0, 32'h0000_7000, 1, 0, 0, 1'b0, 1'b0);
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
